// File: rtl/wlo_pkg.sv
// Shared types for the wordlength-optimisation (WLO) configuration path:
// per-stage wordlength record, controller states and the clamp helper.
package wlo_pkg;

   typedef struct packed {
      logic [7:0] n_int;
      logic [7:0] n_frac;
   } wl_cfg_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      APPLY = 2'd2
   } wl_state_e;

   // Saturate a requested field to its legal maximum.
   function automatic logic [7:0] wl_sat(input logic [7:0] val, input logic [7:0] lim);
      return (val > lim) ? lim : val;
   endfunction

endpackage

// File: rtl/wl_cfg_ctrl.sv
// Wordlength configuration controller. Candidate (num_int, num_frac) pairs
// are written into a shadow bank; a commit stalls the sample stream, drains
// the FIR pipeline, copies shadow to active in a single edge and releases.
import wlo_pkg::*;

module wl_cfg_ctrl #(
   parameter int N_STAGE   = 4,
   parameter int MAX_LEN   = 12,
   parameter int INT_POS   = 8,
   parameter int DRAIN_CYC = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [((N_STAGE < 2) ? 1 : $clog2(N_STAGE)):0] cfg_idx,
   input  logic [7:0]                    cfg_int,
   input  logic [7:0]                    cfg_frac,
   output logic                          cfg_err,
   input  logic                          commit_req,
   output logic                          commit_done,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          dp_valid,
   input  logic                          dp_ready,
   output logic [N_STAGE*8-1:0]          num_int_o,
   output logic [N_STAGE*8-1:0]          num_frac_o
);

   // The index carries one bit beyond what selects a stage, so that
   // out-of-range indices from the optimiser can be seen and rejected.
   localparam int SEL_W = (N_STAGE < 2) ? 1 : $clog2(N_STAGE);
   localparam int IDX_W = SEL_W + 1;
   localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

   localparam logic [7:0] INT_MAX  = 8'(MAX_LEN - INT_POS);
   localparam logic [7:0] FRAC_MAX = 8'(INT_POS);
   localparam wl_cfg_t    WL_DEFAULT = '{n_int: INT_MAX, n_frac: FRAC_MAX};

   wl_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              armed_q;
   wl_cfg_t           shadow_q [N_STAGE];
   wl_cfg_t           active_q [N_STAGE];

   logic cfg_wr, idx_ok, int_clamp, frac_clamp, commit_go;

   assign cfg_wr     = cfg_valid & cfg_ready;
   assign idx_ok     = cfg_idx < IDX_W'(N_STAGE);
   assign int_clamp  = cfg_int  > INT_MAX;
   assign frac_clamp = cfg_frac > FRAC_MAX;
   // A commit needs commit_req to have been seen low in IDLE since the last one.
   assign commit_go  = (state_q == IDLE) & commit_req & armed_q;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: IDLE -> DRAIN (or straight to APPLY with no drain) -> APPLY -> IDLE.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (commit_go) state_d = (DRAIN_CYC == 0) ? APPLY : DRAIN;
         DRAIN:   if (cnt_q == CNT_W'(1)) state_d = APPLY;
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: stream passes through only in IDLE; stalled while draining/applying.
   always_comb begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      dp_valid  = 1'b0;
      if (state_q == IDLE) begin
         cfg_ready = 1'b1;
         in_ready  = dp_ready;
         dp_valid  = in_valid;
      end
   end

   // Drain counter: loaded on commit, counts down to 1 while in DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt_q <= '0;
      else if (commit_go)         cnt_q <= CNT_W'(DRAIN_CYC);
      else if (state_q == DRAIN)  cnt_q <= cnt_q - CNT_W'(1);
   end

   // Commit edge arming: disarm on commit, re-arm once commit_req is low in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                armed_q <= 1'b1;
      else if (commit_go)                        armed_q <= 1'b0;
      else if (state_q == IDLE && !commit_req)   armed_q <= 1'b1;
   end

   // Shadow and active banks: writes land in shadow, APPLY copies the whole bank at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: both banks are reset on purpose; the datapath must come up in full-width pass-through.
         for (int i = 0; i < N_STAGE; i++) begin
            shadow_q[i] <= WL_DEFAULT;
            active_q[i] <= WL_DEFAULT;
         end
      end else begin
         if (cfg_wr && idx_ok)
            shadow_q[cfg_idx[SEL_W-1:0]] <= '{n_int:  wl_sat(cfg_int,  INT_MAX),
                                              n_frac: wl_sat(cfg_frac, FRAC_MAX)};
         if (state_q == APPLY)
            active_q <= shadow_q;
      end
   end

   // Status pulses: error on a dropped/clamped write, done the cycle after APPLY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err     <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         cfg_err     <= cfg_wr & (!idx_ok | int_clamp | frac_clamp);
         commit_done <= (state_q == APPLY);
      end
   end

   // Flatten the active bank onto the per-stage output buses.
   always_comb begin
      num_int_o  = '0;
      num_frac_o = '0;
      for (int i = 0; i < N_STAGE; i++) begin
         num_int_o[i*8 +: 8]  = active_q[i].n_int;
         num_frac_o[i*8 +: 8] = active_q[i].n_frac;
      end
   end

endmodule

// File: tb/tb_wl_cfg_ctrl.sv
// Scoreboard bench for wl_cfg_ctrl: stimulus pushes expected commit snapshots
// and expected error flags; a monitor pops and compares as the DUT responds.
module tb_wl_cfg_ctrl;

   logic        clk, rst_n;
   logic        cfg_valid, cfg_ready;
   logic [2:0]  cfg_idx;
   logic [7:0]  cfg_int, cfg_frac;
   logic        cfg_err;
   logic        commit_req, commit_done;
   logic        in_valid, in_ready, dp_valid, dp_ready;
   logic [31:0] num_int_o, num_frac_o;

   wl_cfg_ctrl #(.N_STAGE(4), .MAX_LEN(12), .INT_POS(8), .DRAIN_CYC(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_err(cfg_err),
      .commit_req(commit_req), .commit_done(commit_done),
      .in_valid(in_valid), .in_ready(in_ready), .dp_valid(dp_valid), .dp_ready(dp_ready),
      .num_int_o(num_int_o), .num_frac_o(num_frac_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;

   logic [63:0] exp_commit_q [$];
   logic        exp_err_q [$];
   logic        wr_pend;

   // Expected shadow contents (hand-computed stored values).
   logic [7:0] m_int  [4];
   logic [7:0] m_frac [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] snap();
      logic [31:0] vi, vf;
      for (int i = 0; i < 4; i++) begin
         vi[i*8 +: 8] = m_int[i];
         vf[i*8 +: 8] = m_frac[i];
      end
      return {vi, vf};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_int[i]  = 8'd4;
         m_frac[i] = 8'd8;
      end
   endtask

   // Flag writes accepted at each edge so the monitor knows when cfg_err is due.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_pend <= 1'b0;
      else        wr_pend <= cfg_valid & cfg_ready;
   end

   // Monitor: compares DUT responses against the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (commit_done === 1'b1) begin
            done_seen++;
            if (exp_commit_q.size() == 0) begin
               check("commit_done_spurious", commit_done, 0);
            end else begin
               logic [63:0] s;
               s = exp_commit_q.pop_front();
               check("commit_num_int",  num_int_o,  s[63:32]);
               check("commit_num_frac", num_frac_o, s[31:0]);
            end
         end
         if (wr_pend && exp_err_q.size() != 0) begin
            logic e;
            e = exp_err_q.pop_front();
            check("cfg_err", cfg_err, e);
         end else if (cfg_err !== 1'b0) begin
            check("cfg_err_spurious", cfg_err, 0);
         end
      end
   end

   // Issue one config write; the stored values and error flag are given by hand.
   task automatic cfg_write(input logic [2:0] idx, input logic [7:0] vi, input logic [7:0] vf,
                            input logic [7:0] st_i, input logic [7:0] st_f, input logic err,
                            input logic with_commit);
      cfg_valid  = 1'b1;
      cfg_idx    = idx;
      cfg_int    = vi;
      cfg_frac   = vf;
      if (with_commit) commit_req = 1'b1;
      exp_err_q.push_back(err);
      if (idx < 4) begin
         m_int[idx]  = st_i;
         m_frac[idx] = st_f;
      end
      if (with_commit) exp_commit_q.push_back(snap());
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask

   // Wait for commit_done, counting stalled (in_ready low) cycles on the way.
   task automatic wait_commit(output int low_cycles);
      bit seen = 0;
      low_cycles = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (commit_done === 1'b1) seen = 1;
         else if (in_ready === 1'b0) low_cycles++;
      end
      if (!seen) check("commit_timeout", commit_done, 1);
   endtask

   task automatic commit_pulse(output int low_cycles);
      commit_req = 1'b1;
      exp_commit_q.push_back(snap());
      @(posedge clk);
      #1 commit_req = 1'b0;
      wait_commit(low_cycles);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int low;
      int d0;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_int = '0; cfg_frac = '0;
      commit_req = 1'b0; in_valid = 1'b0; dp_ready = 1'b0;
      model_reset();

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_num_int",  num_int_o,  32'h04040404);
      check("rst_num_frac", num_frac_o, 32'h08080808);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_commit_done", commit_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // IDLE stream pass-through.
      in_valid = 1'b1; dp_ready = 1'b0;
      #2;
      check("idle_dp_valid_hi", dp_valid, 1);
      check("idle_in_ready_lo", in_ready, 0);
      in_valid = 1'b0; dp_ready = 1'b1;
      #2;
      check("idle_dp_valid_lo", dp_valid, 0);
      check("idle_in_ready_hi", in_ready, 1);
      in_valid = 1'b1;

      // Shadow isolation: write without commit leaves active untouched.
      @(posedge clk); #1;
      cfg_write(3'd1, 8'd2, 8'd5, 8'd2, 8'd5, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("iso_num_int1",  num_int_o[15:8],  8'd4);
         check("iso_num_frac1", num_frac_o[15:8], 8'd8);
      end

      // Commit timing: 6 DRAIN + 1 APPLY stalled cycles, then done with new values.
      @(posedge clk); #1;
      commit_pulse(low);
      check("commit_stall_cycles", low, 7);
      check("post_commit_in_ready", in_ready, 1);

      // Clamp and drop rules.
      @(posedge clk); #1;
      cfg_write(3'd0, 8'd9, 8'd12, 8'd4, 8'd8, 1'b1, 1'b0);
      cfg_write(3'd2, 8'd3, 8'd12, 8'd3, 8'd8, 1'b1, 1'b0);
      cfg_write(3'd5, 8'd1, 8'd1,  8'd0, 8'd0, 1'b1, 1'b0);
      cfg_write(3'd0, 8'd0, 8'd3,  8'd0, 8'd3, 1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      commit_pulse(low);
      check("commit2_stall_cycles", low, 7);

      // Same-cycle write + commit, commit_req held high: one commit only.
      @(posedge clk); #1;
      d0 = done_seen;
      cfg_write(3'd3, 8'd1, 8'd6, 8'd1, 8'd6, 1'b0, 1'b1);
      repeat (25) @(posedge clk);
      #1 check("held_commit_single_done", done_seen - d0, 1);
      commit_req = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Reset in DRAIN cycle 3: defaults back, pending commit lost.
      cfg_write(3'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
      d0 = done_seen;
      commit_req = 1'b1;
      @(posedge clk);
      #1 commit_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      exp_err_q.delete();
      @(negedge clk);
      check("mid_rst_num_int",  num_int_o,  32'h04040404);
      check("mid_rst_num_frac", num_frac_o, 32'h08080808);
      check("mid_rst_cfg_ready", cfg_ready, 1);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_dp_valid", dp_valid, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1 check("mid_rst_no_done", done_seen - d0, 0);

      // Commit after reset must publish default (reset) shadow contents.
      commit_pulse(low);
      check("post_rst_stall_cycles", low, 7);

      repeat (3) @(posedge clk);
      check("err_queue_drained", exp_err_q.size(), 0);
      check("commit_queue_drained", exp_commit_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
